ttl_74165_sync: RTL and testbench



---
 rtl/ttl_74165_sync_pkg.sv | 14 +
 rtl/ttl_edge_rise_sync.sv | 28 ++
 rtl/ttl_74165_sync.sv | 61 ++++++
 tb/tb_ttl_74165_sync.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_74165_sync_pkg.sv
// ============================================================================
// Module  : ttl_74165_sync_pkg
// Brief   : Local constants for the synchronous 74LS165 model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ttl_74165_sync_pkg;
  localparam int   SR_WIDTH      = 8;
  // History of 1 means a clock level already high at reset release is not an edge
  localparam logic EDGE_HIST_RST = 1'b1;
endpackage

`default_nettype wire

// File: rtl/ttl_edge_rise_sync.sv
// ============================================================================
// Module  : ttl_edge_rise_sync
// Brief   : Rising-edge detector for a level sampled on the system clock.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ttl_edge_rise_sync #(
  parameter logic HIST_RST = 1'b1
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Lvl,
  output logic Rise
);

  logic r_last;

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_last <= HIST_RST;
    else          r_last <= Lvl;
  end

  assign Rise = Lvl & ~r_last;

endmodule

`default_nettype wire

// File: rtl/ttl_74165_sync.sv
// ============================================================================
// Module  : ttl_74165_sync
// Brief   : 74LS165 parallel-in/serial-out shift register, MSB (H) first.
//           Define TTL_74165_QTAP_EN to expose the full register on Q_tap.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ttl_74165_sync
  import ttl_74165_sync_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Cen,
  input  logic                Clk_inh,
  input  logic                Sh_Ld_n,
  input  logic                Ser,
  input  logic [SR_WIDTH-1:0] D,
`ifdef TTL_74165_QTAP_EN
  output logic [SR_WIDTH-1:0] Q_tap,
`endif
  output logic                QH,
  output logic                QH_n
);

  logic [SR_WIDTH-1:0] r_sr;
  logic                w_ck;
  logic                w_ck_rise;

  // Inhibit is ORed into the clock as on the part, so its own rising edge shifts
  assign w_ck = Cen | Clk_inh;

  ttl_edge_rise_sync #(
    .HIST_RST (EDGE_HIST_RST)
  ) u_ck_edge (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Lvl     (w_ck),
    .Rise    (w_ck_rise)
  );

  // Load wins over shift; an edge coinciding with load is dropped, not deferred
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      r_sr <= '0;
    else if (!Sh_Ld_n)
      r_sr <= D;
    else if (w_ck_rise)
      r_sr <= {r_sr[SR_WIDTH-2:0], Ser};
  end

  assign QH   = r_sr[SR_WIDTH-1];
  assign QH_n = ~r_sr[SR_WIDTH-1];

`ifdef TTL_74165_QTAP_EN
  assign Q_tap = r_sr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ttl_74165_sync.sv
// ============================================================================
// Module  : tb_ttl_74165_sync
// Brief   : Directed self-checking bench for ttl_74165_sync (two-stage cascade).
// Rev     : 1.1  failure counting in every check
// ============================================================================
`default_nettype none

module tb_ttl_74165_sync;

    logic       Clk = 1'b0;
    logic       Reset_n, Cen, Clk_inh, Sh_Ld_n, Ser, cascade;
    logic [7:0] D, D2;
    logic       QH, QH_n, QH2, QH2_n;
    logic       ser1;
`ifdef TTL_74165_QTAP_EN
    logic [7:0] q_tap, q_tap2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    assign ser1 = cascade ? QH2 : Ser;

    ttl_74165_sync u_dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Cen     (Cen),
        .Clk_inh (Clk_inh),
        .Sh_Ld_n (Sh_Ld_n),
        .Ser     (ser1),
        .D       (D),
`ifdef TTL_74165_QTAP_EN
        .Q_tap   (q_tap),
`endif
        .QH      (QH),
        .QH_n    (QH_n)
    );

    ttl_74165_sync u_dut2 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Cen     (Cen),
        .Clk_inh (Clk_inh),
        .Sh_Ld_n (Sh_Ld_n),
        .Ser     (Ser),
        .D       (D2),
`ifdef TTL_74165_QTAP_EN
        .Q_tap   (q_tap2),
`endif
        .QH      (QH2),
        .QH_n    (QH2_n)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pulse;
        Cen = 1'b0;
        tick(2);
        Cen = 1'b1;
        tick(2);
    endtask

    task automatic load(input logic [7:0] d);
        D       = d;
        Sh_Ld_n = 1'b0;
        tick(1);
        Sh_Ld_n = 1'b1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Cen = 1'b1; Clk_inh = 1'b0; Sh_Ld_n = 1'b1;
        Ser = 1'b1; D = 8'hFF; D2 = 8'h00; cascade = 1'b0;
        tick(2);
        checks++;
        if ({QH, QH_n} !== 2'b01) begin
            errors++;
            $display("FAIL reset_out: got QH=%b QH_n=%b, expected QH=0 QH_n=1", QH, QH_n);
        end
        Reset_n = 1'b1;
        tick(2);
        Ser = 1'b0;
        repeat (7) pulse;
        checks++;
        if (QH !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_noshift: got QH=%b, expected 0", QH);
        end
    endtask

    task automatic test_load_shift;
        logic [7:0] pat;
        logic       exp;
        pat = 8'hA5;
        Ser = 1'b0;
        load(pat);
        checks++;
        if ({QH, QH_n} !== {pat[7], ~pat[7]}) begin
            errors++;
            $display("FAIL load_latency: got QH=%b QH_n=%b, expected QH=%b", QH, QH_n, pat[7]);
        end
        for (int k = 1; k <= 8; k++) begin
            pulse;
            exp = (k < 8) ? pat[7-k] : 1'b0;
            checks++;
            if ({QH, QH_n} !== {exp, ~exp}) begin
                errors++;
                $display("FAIL shift_A5[%0d]: got QH=%b QH_n=%b, expected QH=%b", k, QH, QH_n, exp);
            end
        end
    endtask

    task automatic test_inhibit;
        Ser = 1'b0;
        load(8'h80);
        Clk_inh = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pulse;
            checks++;
            if (QH !== 1'b1) begin
                errors++;
                $display("FAIL inhibit_hold[%0d]: got QH=%b, expected 1", k, QH);
            end
        end
        Clk_inh = 1'b0;
        tick(1);
        pulse;
        checks++;
        if (QH !== 1'b0) begin
            errors++;
            $display("FAIL inhibit_release: got QH=%b, expected 0", QH);
        end
    endtask

    task automatic test_or_edge;
        Ser = 1'b0;
        load(8'h80);
        Cen = 1'b0; Clk_inh = 1'b0;
        tick(2);
        checks++;
        if (QH !== 1'b1) begin
            errors++;
            $display("FAIL or_edge_fall: got QH=%b, expected 1", QH);
        end
        Clk_inh = 1'b1;
        tick(3);
        checks++;
        if (QH !== 1'b0) begin
            errors++;
            $display("FAIL or_edge_shift: got QH=%b, expected 0", QH);
        end
        Clk_inh = 1'b0;
        Cen = 1'b1;
        tick(2);
    endtask

    task automatic test_load_priority;
        logic [7:0] sh;
        Ser = 1'b0;
        Cen = 1'b0;
        tick(2);
        D = 8'h3C; Sh_Ld_n = 1'b0; Cen = 1'b1;
        tick(1);
        Sh_Ld_n = 1'b1;
        checks++;
        if (QH !== 1'b0) begin
            errors++;
            $display("FAIL prio_load: got QH=%b, expected 0", QH);
        end
`ifdef TTL_74165_QTAP_EN
        checks++;
        if (q_tap !== 8'h3C) begin
            errors++;
            $display("FAIL prio_qtap: got %h, expected 3c", q_tap);
        end
`endif
        tick(2);
        for (int k = 1; k <= 6; k++) begin
            pulse;
            sh = 8'h3C << k;
            checks++;
            if (QH !== sh[7]) begin
                errors++;
                $display("FAIL prio_shift[%0d]: got QH=%b, expected %b", k, QH, sh[7]);
            end
        end
    endtask

    task automatic test_reset_mid;
        Ser = 1'b0;
        load(8'hA5);
        pulse;
        pulse;
        checks++;
        if (QH !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got QH=%b, expected 1", QH);
        end
        Reset_n = 1'b0; Cen = 1'b0;
        tick(1);
        checks++;
        if ({QH, QH_n} !== 2'b01) begin
            errors++;
            $display("FAIL mid_reset: got QH=%b QH_n=%b, expected QH=0 QH_n=1", QH, QH_n);
        end
`ifdef TTL_74165_QTAP_EN
        checks++;
        if (q_tap !== 8'h00) begin
            errors++;
            $display("FAIL mid_qtap: got %h, expected 00", q_tap);
        end
`endif
        Reset_n = 1'b1; Cen = 1'b1;
        tick(2);
    endtask

    task automatic test_cascade;
        logic [15:0] cat;
        logic [15:0] sh;
        cat = 16'hF00F;
        Ser = 1'b0;
        cascade = 1'b1;
        D = 8'hF0; D2 = 8'h0F; Sh_Ld_n = 1'b0;
        tick(1);
        Sh_Ld_n = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) pulse;
            sh = cat << k;
            checks++;
            if (QH !== sh[15]) begin
                errors++;
                $display("FAIL cascade_qh[%0d]: got QH=%b, expected %b", k, QH, sh[15]);
            end
`ifdef TTL_74165_QTAP_EN
            checks++;
            if (q_tap !== sh[15:8]) begin
                errors++;
                $display("FAIL cascade_qtap[%0d]: got %h, expected %h", k, q_tap, sh[15:8]);
            end
`endif
        end
        cascade = 1'b0;
    endtask

    initial begin
        test_reset;
        test_load_shift;
        test_inhibit;
        test_or_edge;
        test_load_priority;
        test_reset_mid;
        test_cascade;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
